// File: rtl/mdu_if.sv
// Command/result bundle between the execute-stage controller and the
// sequential multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers:
// shift-add multiply (LSB first) and restoring divide (MSB first) on magnitudes.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_muldiv;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_fits;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_muldiv = (bus.op[2] == 1'b0);
    assign w_rs_neg    = bus.op[0] & bus.rs_data[WIDTH-1];
    assign w_rt_neg    = bus.op[0] & bus.rt_data[WIDTH-1];
    assign w_rs_mag    = w_rs_neg ? -bus.rs_data : bus.rs_data;
    assign w_rt_mag    = w_rt_neg ? -bus.rt_data : bus.rt_data;

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                       + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide: dividend shifts out of r_acc's low half while quotient bits shift in.
    assign w_div_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_fits  = ~w_div_diff[WIDTH];

    // A zero divisor leaves the dividend magnitude as remainder; re-signing it
    // restores the raw dividend, so only the quotient needs overriding.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_div0 ? {WIDTH{1'b1}}
                  : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_is_muldiv) begin
                            r_state  <= ST_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_LOAD;
                            r_is_div <= bus.op[1];
                            r_neg_q  <= w_rs_neg ^ w_rt_neg;
                            r_neg_r  <= w_rs_neg;
                            r_div0   <= bus.op[1] && (bus.rt_data == '0);
                            r_opnd   <= bus.op[1] ? w_rt_mag : w_rs_mag;
                            r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_rs_mag : w_rt_mag)};
                            r_rem    <= '0;
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.rs_data;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.rs_data;
                        end
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        r_rem <= w_div_fits ? w_div_diff : w_div_shift;
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_fits};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
